// File: rtl/rand_lcg_gen_if.sv
// Valid/ready sample stream carrying one pseudo-random value per transfer.
interface rand_lcg_gen_if #(
    parameter int unsigned OUT_W = 15
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/rand_lcg_gen.sv
// Parametrised LCG random source with synchronous seeding and a valid/ready output.
// Optional rejection sampling against range_max is enabled by defining RAND_RANGE_EN.
module rand_lcg_gen #(
    parameter int unsigned          STATE_W  = 32,
    parameter int unsigned          OUT_W    = 15,
    parameter int unsigned          OUT_LSB  = 16,
    parameter logic [STATE_W-1:0]   MULT     = STATE_W'(32'h343FD),
    parameter logic [STATE_W-1:0]   INC      = STATE_W'(32'h269EC3),
    parameter bit                   FREE_RUN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_load,
    input  logic [STATE_W-1:0] seed,
    output logic [15:0]        xfer_cnt,
    output logic               seeded,
`ifdef RAND_RANGE_EN
    input  logic [OUT_W-1:0]   range_max,
`endif
    rand_lcg_gen_if.master     bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e             r_fsm;
    state_e             w_fsm_nxt;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [STATE_W-1:0] w_step;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic [CNT_W-1:0]   w_xfer_cnt_nxt;
    logic               r_seeded;
    logic               w_seeded_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [OUT_W-1:0]   w_extract;
    logic               w_reject_c;
    logic               w_valid;
    logic               w_xfer;

    assign w_step    = r_state * MULT + INC;
    assign w_extract = r_state[OUT_LSB +: OUT_W];

    // A sample above range_max is hidden and skipped so accepted values stay uniform.
`ifdef RAND_RANGE_EN
    assign w_reject_c = (r_fsm == ST_RUN) && (w_extract > range_max);
`else
    assign w_reject_c = 1'b0;
`endif

    assign w_valid = r_valid && !w_reject_c;
    assign w_xfer  = w_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= ST_IDLE;
            r_state    <= '0;
            r_xfer_cnt <= '0;
            r_seeded   <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_state    <= w_state_nxt;
            r_xfer_cnt <= w_xfer_cnt_nxt;
            r_seeded   <= w_seeded_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_state_nxt    = r_state;
        w_xfer_cnt_nxt = r_xfer_cnt;
        w_seeded_nxt   = r_seeded;

        case (r_fsm)
            ST_IDLE: begin
                if (seed_load) begin
                    w_state_nxt    = seed;
                    w_xfer_cnt_nxt = '0;
                    w_fsm_nxt      = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (seed_load) begin
                    w_state_nxt    = seed;
                    w_xfer_cnt_nxt = '0;
                end else begin
                    w_state_nxt  = w_step;
                    w_seeded_nxt = 1'b1;
                    w_fsm_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Reseed beats a same-cycle transfer: the sample is consumed but the count restarts.
                if (seed_load) begin
                    w_state_nxt    = seed;
                    w_xfer_cnt_nxt = '0;
                    w_fsm_nxt      = ST_PRIME;
                end else begin
                    if (FREE_RUN || w_xfer || w_reject_c) begin
                        w_state_nxt = w_step;
                    end
                    if (w_xfer) begin
                        w_xfer_cnt_nxt = r_xfer_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase

        w_valid_nxt = (w_fsm_nxt == ST_RUN);
    end

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_extract;
    assign xfer_cnt      = r_xfer_cnt;
    assign seeded        = r_seeded;
endmodule

// File: tb/tb_rand_lcg_gen.sv
// Directed bench: one on-demand and one free-running generator fed from a shared seed source.
module tb_rand_lcg_gen;
    localparam int unsigned STATE_W = 32;
    localparam int unsigned OUT_W   = 15;

    logic               clk;
    logic               rst_n;
    logic               seed_load;
    logic [STATE_W-1:0] seed;
    logic [OUT_W-1:0]   range_max0;
    logic [OUT_W-1:0]   range_max1;
    logic [15:0]        xfer0;
    logic [15:0]        xfer1;
    logic               seeded0;
    logic               seeded1;

    int n_vec = 0;
    int n_err = 0;

    rand_lcg_gen_if #(.OUT_W(OUT_W)) if0 ();
    rand_lcg_gen_if #(.OUT_W(OUT_W)) if1 ();

    rand_lcg_gen #(.FREE_RUN(1'b0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .xfer_cnt  (xfer0),
        .seeded    (seeded0),
`ifdef RAND_RANGE_EN
        .range_max (range_max0),
`endif
        .bus       (if0.master)
    );

    rand_lcg_gen #(.FREE_RUN(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .xfer_cnt  (xfer1),
        .seeded    (seeded1),
`ifdef RAND_RANGE_EN
        .range_max (range_max1),
`endif
        .bus       (if1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        seed_load     = 1'b0;
        seed          = '0;
        range_max0    = '1;
        range_max1    = '1;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        #12;
        chk("rst_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_xfer0", 32'(xfer0), 32'd0);
        chk("rst_seeded0", 32'(seeded0), 32'd0);
        rst_n = 1'b1;
        tick();

        // On-demand stream from seed 1 with the consumer always ready.
        seed = 32'd1; seed_load = 1'b1; if0.out_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("prime_valid0", 32'(if0.out_valid), 32'd0);
        chk("prime_xfer_ignored", 32'(xfer0), 32'd0);
        tick();
        chk("first_valid0", 32'(if0.out_valid), 32'd1);
        chk("first_data0", 32'(if0.out_data), 32'd41);
        chk("first_seeded0", 32'(seeded0), 32'd1);
        tick();
        chk("s2_data0", 32'(if0.out_data), 32'd18467);
        chk("s2_xfer0", 32'(xfer0), 32'd1);
        tick();
        chk("s3_data0", 32'(if0.out_data), 32'd6334);
        chk("s3_xfer0", 32'(xfer0), 32'd2);
        tick();
        if0.out_ready = 1'b0;
        chk("s4_xfer0", 32'(xfer0), 32'd3);
        chk("s4_data0", 32'(if0.out_data), 32'd26500);
        tick();
        chk("s4_stall_data0", 32'(if0.out_data), 32'd26500);

        // Reseed with the consumer stalled: sample must hold for ten cycles.
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_data0", 32'(if0.out_data), 32'd41);
            chk("hold_xfer0", 32'(xfer0), 32'd0);
            tick();
        end
        if0.out_ready = 1'b1;
        chk("hold_release_data0", 32'(if0.out_data), 32'd41);
        tick();
        chk("after_hold_data0", 32'(if0.out_data), 32'd18467);
        chk("after_hold_xfer0", 32'(xfer0), 32'd1);
        tick(); tick(); tick(); tick();
        chk("five_data0", 32'(if0.out_data), 32'd15724);
        chk("five_xfer0", 32'(xfer0), 32'd5);

        // Reseed coinciding with a transfer: count clears, stream restarts.
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("reseed_valid0", 32'(if0.out_valid), 32'd0);
        chk("reseed_xfer0", 32'(xfer0), 32'd0);
        tick();
        chk("restart_valid0", 32'(if0.out_valid), 32'd1);
        chk("restart_data0", 32'(if0.out_data), 32'd41);
        chk("restart_xfer0", 32'(xfer0), 32'd0);
        tick();
        chk("restart2_data0", 32'(if0.out_data), 32'd18467);
        chk("restart2_xfer0", 32'(xfer0), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", 32'(if0.out_valid), 32'd0);
        chk("arst_xfer0", 32'(xfer0), 32'd0);
        chk("arst_seeded0", 32'(seeded0), 32'd0);
        chk("arst_seeded1", 32'(seeded1), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_valid0", 32'(if0.out_valid), 32'd0);
            chk("idle_xfer0", 32'(xfer0), 32'd0);
        end

        // Free-running generator advances every cycle with no consumer.
        if0.out_ready = 1'b0;
        seed = 32'd1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        chk("fr_valid1", 32'(if1.out_valid), 32'd1);
        chk("fr_d1", 32'(if1.out_data), 32'd41);
        tick();
        chk("fr_d2", 32'(if1.out_data), 32'd18467);
        tick();
        chk("fr_d3", 32'(if1.out_data), 32'd6334);
        chk("fr_xfer_none", 32'(xfer1), 32'd0);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;
        chk("fr_xfer1", 32'(xfer1), 32'd1);
        chk("fr_d4", 32'(if1.out_data), 32'd26500);
        chk("fr_hold_d0", 32'(if0.out_data), 32'd41);

        // Zero seed is legal; the first sample comes from INC alone.
        seed = 32'd0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        chk("zero_seed_data0", 32'(if0.out_data), 32'd38);
        chk("zero_seed_valid0", 32'(if0.out_valid), 32'd1);

`ifdef RAND_RANGE_EN
        // Rejection sampling against a small range.
        range_max0 = OUT_W'(100);
        seed = 32'd1; seed_load = 1'b1; if0.out_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        chk("rng_first_valid0", 32'(if0.out_valid), 32'd1);
        chk("rng_first_data0", 32'(if0.out_data), 32'd41);
        tick();
        chk("rng_rej1_valid0", 32'(if0.out_valid), 32'd0);
        chk("rng_rej1_data0", 32'(if0.out_data), 32'd18467);
        chk("rng_rej1_xfer0", 32'(xfer0), 32'd1);
        tick();
        chk("rng_rej2_valid0", 32'(if0.out_valid), 32'd0);
        chk("rng_rej2_data0", 32'(if0.out_data), 32'd6334);
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("rng_bound0", 32'(if0.out_valid && (if0.out_data > OUT_W'(100))), 32'd0);
        end
        if0.out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
